rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
Registered RISC-V instruction decode stage between the fetch and register-read stages, parametrised in data width (RV32/RV64) and optional M-extension recognition. It accepts fetched instructions over a valid/ready handshake, fully decodes fields and the format-selected immediate, and classifies the instruction as a one-hot op type. It flags illegal encodings and holds results in a two-entry skid buffer so that in_ready is driven from a register. A saturating illegal-instruction counter is provided for debug.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets the widths of the PC and the immediate.
ENABLE_M, 0, when 1, funct7=0000001 on R-type is legal (MUL/DIV family).
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  discards all buffered and incoming instructions.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage can accept; registered.
in_instr  input  32  raw instruction word.
in_pc  input  XLEN  PC of in_instr.
out_valid  output  1  decoded entry available.
out_ready  input  1  downstream accepts.
out_pc  output  XLEN  PC of the decoded entry.
out_opcode  output  7  instr[6:0].
out_rd  output  5  instr[11:7].
out_funct3  output  3  instr[14:12].
out_rs1  output  5  instr[19:15].
out_rs2  output  5  instr[24:20].
out_funct7  output  7  instr[31:25].
out_imm  output  XLEN  format-selected, sign-extended immediate.
out_optype  output  11  one-hot class (see Behaviour).
out_illegal  output  1  entry is an illegal encoding.
illegal_count  output  CNT_W  saturating count of illegal entries delivered downstream.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Both buffer entries are invalid; out_valid=0; in_ready=1.
  - All out_* data fields, out_illegal and illegal_count are 0.
- Storage:
  - Main entry M drives the out_* ports; skid entry S holds overflow.
  - in_ready = !S.valid, registered.
  - An input transfer occurs when in_valid and in_ready; an output transfer occurs when out_valid and out_ready.
- Per-edge update, when flush=0:
  - Input transfer with M empty, or with M being consumed and S empty: the decoded input loads into M.
  - Input transfer while M is full and not consumed: the decoded input loads into S.
  - M consumed and S valid: S moves to M. No input transfer can coincide, because in_ready=0.
  - Ordering is strictly FIFO.
- Latency and throughput: the first out_valid appears 1 cycle after acceptance; full throughput of 1 instruction per cycle with out_ready held high.
- Flush: at the next edge, M and S are invalidated and an input transfer in the same cycle is discarded. in_ready=1 in the following cycle. illegal_count is unaffected.
- Immediate selection (sign bit instr[31], extended to XLEN):
  - I-format for opcodes 0010011, 0000011, 1100111.
  - S-format for 0100011.
  - B-format for 1100011 (bit0=0).
  - U-format for 0110111 and 0010111 (low 12 bits zero, sign-extended above bit 31).
  - J-format for 1101111 (bit0=0).
  - 0 for 1110011 and for illegal entries.
- out_optype one-hot, LSB first: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM. Bit 10 is reserved and always 0 for legal entries. An illegal entry drives all ones (11'h7FF).
- Illegal conditions (any one is sufficient):
  - instr[1:0]!=2'b11.
  - Opcode not in the list above.
  - R-type funct7 not in {0000000, 0100000, 0000001 when ENABLE_M=1}.
  - R-type funct7=0100000 with funct3 not in {000, 101}.
  - I-ALU funct3=001 with funct7!=0 (XLEN=32), or funct3=101 with funct7 not in {0000000, 0100000} (XLEN=32).
  - LOAD funct3=111, or funct3 in {011, 110} when XLEN=32.
  - STORE funct3 >= 100, or funct3=011 when XLEN=32.
  - BRANCH funct3 in {010, 011}.
  - JALR funct3!=000.
- Raw fields (out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7) are always passed through unchanged, including for illegal entries.
- illegal_count: increments by 1 on each output transfer with out_illegal=1 and saturates at all ones.

Test Plan:
- Reset then ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, out_imm=all ones (XLEN wide), out_optype=11'b00000000010, out_rd=1, out_illegal=0.
- Back-to-back LUI 0x800000B7, SW 0x00112623, BEQ 0xFE000EE3 with out_ready=1 -> 3 consecutive valid outputs:
  - LUI: out_imm=0xFFFFFFFF80000000 at XLEN=64.
  - SW: imm=12.
  - BEQ: imm=-4.
- Stall: out_ready=0 while 2 instructions are offered -> both are captured (M and S) and in_ready=0 after the second; release out_ready -> in-order delivery, then in_ready=1.
- Illegal: 0x0000007F, and MUL 0x02208033 with ENABLE_M=0 -> out_optype=11'h7FF and out_illegal=1 for each; illegal_count=2 after both are consumed. The same MUL with ENABLE_M=1 -> optype R, legal.
- Flush with M and S full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale entry emitted.
- rst_n asserted mid-stall with S valid -> out_valid=0 and in_ready=1 immediately (asynchronous), illegal_count=0.

Source files
------------

// File: rtl/rv_decode_stage_if.sv
// rtl/rv_decode_stage_if.sv - fetch-side and decode-side handshake bundle for rv_decode_stage
interface rv_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [10:0]     out_optype;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_optype, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
               out_rs1, out_rs2, out_funct7, out_imm, out_optype, out_illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RISC-V decode stage with two-entry skid buffer
module rv_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    rv_decode_stage_if.slave   bus,
    output logic [CNT_W-1:0]   illegal_count
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [10:0]     optype;
        logic            illegal;
    } entry_t;

    entry_t      m, s, dec;
    logic        m_valid, s_valid;
    logic        in_fire, out_fire;
    logic [31:0] ins;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] imm32;
    logic [3:0]  cls;
    logic        bad;

    assign ins = bus.in_instr;
    assign op  = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    always_comb begin
        imm32 = 32'd0;
        cls   = 4'd0;
        bad   = 1'b0;
        case (op)
            7'b0110011: begin
                cls = 4'd0;
                bad = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                        (ENABLE_M && f7 == 7'b0000001));
            end
            7'b0010011: begin
                cls   = 4'd1;
                imm32 = {{20{ins[31]}}, ins[31:20]};
                // RV64 uses instr[25] as the sixth shamt bit, so only RV32 restricts funct7
                if (XLEN == 32)
                    bad = (f3 == 3'b001 && f7 != 7'b0000000) ||
                          (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            7'b0000011: begin
                cls   = 4'd2;
                imm32 = {{20{ins[31]}}, ins[31:20]};
                bad   = (f3 == 3'b111) || (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
            end
            7'b0100011: begin
                cls   = 4'd3;
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                bad   = f3[2] || (XLEN == 32 && f3 == 3'b011);
            end
            7'b1100011: begin
                cls   = 4'd4;
                imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                bad   = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b1101111: begin
                cls   = 4'd5;
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin
                cls   = 4'd6;
                imm32 = {{20{ins[31]}}, ins[31:20]};
                bad   = (f3 != 3'b000);
            end
            7'b0110111: begin
                cls   = 4'd7;
                imm32 = {ins[31:12], 12'd0};
            end
            7'b0010111: begin
                cls   = 4'd8;
                imm32 = {ins[31:12], 12'd0};
            end
            7'b1110011: cls = 4'd9;
            default:    bad = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) bad = 1'b1;

        dec.pc      = bus.in_pc;
        dec.instr   = ins;
        dec.imm     = bad ? '0 : XLEN'($signed(imm32));
        dec.optype  = bad ? 11'h7FF : (11'd1 << cls);
        dec.illegal = bad;
    end

    assign bus.in_ready = !s_valid;
    assign in_fire      = bus.in_valid && !s_valid;
    assign out_fire     = m_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid       <= 1'b0;
            s_valid       <= 1'b0;
            m             <= '0;
            s             <= '0;
            illegal_count <= '0;
        end else begin
            if (out_fire && m.illegal && illegal_count != '1)
                illegal_count <= illegal_count + CNT_W'(1);
            if (flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (!m_valid || bus.out_ready) begin
                // S always drains before new input can land, since in_ready is low while S is full
                if (s_valid) begin
                    m       <= s;
                    m_valid <= 1'b1;
                    s_valid <= 1'b0;
                end else begin
                    m_valid <= in_fire;
                    if (in_fire) m <= dec;
                end
            end else if (in_fire) begin
                s       <= dec;
                s_valid <= 1'b1;
            end
        end
    end

    assign bus.out_valid   = m_valid;
    assign bus.out_pc      = m.pc;
    assign bus.out_opcode  = m.instr[6:0];
    assign bus.out_rd      = m.instr[11:7];
    assign bus.out_funct3  = m.instr[14:12];
    assign bus.out_rs1     = m.instr[19:15];
    assign bus.out_rs2     = m.instr[24:20];
    assign bus.out_funct7  = m.instr[31:25];
    assign bus.out_imm     = m.imm;
    assign bus.out_optype  = m.optype;
    assign bus.out_illegal = m.illegal;
endmodule
